// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory req/ack handshake bundle
interface fetch_stage_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;

    // Fetch stage side: issues requests, receives data
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: receives requests, returns data
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage driving IF/ID from a req/ack instruction memory
module fetch_stage #(
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] PC_INC   = AW'(2),
    parameter logic [DW-1:0] NOP      = '0,
    parameter int            WAIT_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] PC,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          Flush,
    fetch_stage_if.master imem,
    output logic          StopPC,
    output logic [DW-1:0] IFID_Instr,
    output logic [AW-1:0] IFID_PC,
    output logic [AW-1:0] IFID_PCPlus,
    output logic          IFID_Valid,
    output logic          fetch_err
);

    localparam int            CW       = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_HOLD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;

    // Parking slot for an instruction that arrived while ID was stalled
    logic [DW-1:0] hold_instr_q, hold_instr_d;
    logic [AW-1:0] hold_pc_q, hold_pc_d;
    logic          hold_valid_q, hold_valid_d;

    // Halt seen while a request was still outstanding
    logic          halt_pend_q, halt_pend_d;

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          fetch_err_q, fetch_err_d;

    logic [DW-1:0] ifid_instr_q, ifid_instr_d;
    logic [AW-1:0] ifid_pc_q, ifid_pc_d;
    logic [AW-1:0] ifid_pcplus_q, ifid_pcplus_d;
    logic          ifid_valid_q, ifid_valid_d;

    logic          req_c;
    logic [AW-1:0] addr_c;
    logic          stop_c;
    logic          halt_now;
    logic          counting;

    // Next-state, IF/ID load selection and handshake outputs
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        hold_valid_d  = hold_valid_q;
        halt_pend_d   = halt_pend_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pcplus_d = ifid_pcplus_q;
        ifid_valid_d  = ifid_valid_q;
        req_c         = 1'b0;
        addr_c        = addr_q;
        stop_c        = 1'b1;
        halt_now      = halt_pend_q;

        unique case (state_q)
            S_REQ: begin
                req_c       = 1'b1;
                addr_c      = PC;
                addr_d      = PC;
                halt_now    = Halt | halt_pend_q;
                halt_pend_d = halt_now;
                if (Flush) begin
                    // Redirect: bubble IF/ID, let PC take the target
                    stop_c       = 1'b0;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                    hold_valid_d = 1'b0;
                    if (imem.imem_ack) begin
                        state_d = halt_now ? S_HALTED : S_REQ;
                    end else begin
                        // Request is in flight; keep it stable and drop its data later
                        state_d = S_DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    stop_c = 1'b0;
                    if (Stall) begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc_d    = PC;
                        hold_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        ifid_instr_d  = imem.imem_rdata;
                        ifid_pc_d     = PC;
                        ifid_pcplus_d = PC + PC_INC;
                        ifid_valid_d  = 1'b1;
                        state_d       = halt_now ? S_HALTED : S_REQ;
                    end
                end else if (!Stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                end
            end

            S_HOLD: begin
                halt_now    = Halt | halt_pend_q;
                halt_pend_d = halt_now;
                if (Flush) begin
                    stop_c       = 1'b0;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                    hold_valid_d = 1'b0;
                    state_d      = halt_now ? S_HALTED : S_REQ;
                end else if (!Stall) begin
                    ifid_instr_d  = hold_instr_q;
                    ifid_pc_d     = hold_pc_q;
                    ifid_pcplus_d = hold_pc_q + PC_INC;
                    ifid_valid_d  = hold_valid_q;
                    hold_valid_d  = 1'b0;
                    state_d       = halt_now ? S_HALTED : S_REQ;
                end
            end

            S_DRAIN: begin
                req_c = 1'b1;
                if (Flush) begin
                    stop_c       = 1'b0;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                    hold_valid_d = 1'b0;
                end else if (!Stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                end
                if (imem.imem_ack) begin
                    state_d = halt_pend_q ? S_HALTED : S_REQ;
                end
            end

            S_HALTED: begin
                if (Flush || !Stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        // Timeout tracking: only uninterrupted waiting in the same requesting state counts
        counting = ((state_q == S_REQ) || (state_q == S_DRAIN)) && !imem.imem_ack
                   && (state_d == state_q);
        if (!counting) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIM) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        fetch_err_d = fetch_err_q | (wait_cnt_d == WAIT_LIM);
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            addr_q        <= '0;
            hold_instr_q  <= NOP;
            hold_pc_q     <= '0;
            hold_valid_q  <= 1'b0;
            halt_pend_q   <= 1'b0;
            wait_cnt_q    <= '0;
            fetch_err_q   <= 1'b0;
            ifid_instr_q  <= NOP;
            ifid_pc_q     <= '0;
            ifid_pcplus_q <= '0;
            ifid_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            hold_valid_q  <= hold_valid_d;
            halt_pend_q   <= halt_pend_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_err_q   <= fetch_err_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pcplus_q <= ifid_pcplus_d;
            ifid_valid_q  <= ifid_valid_d;
        end
    end

    // The reset cycle never requests and always holds the PC
    assign imem.imem_req  = req_c & ~rst;
    assign imem.imem_addr = addr_c;
    assign StopPC         = stop_c | rst;

    assign IFID_Instr  = ifid_instr_q;
    assign IFID_PC     = ifid_pc_q;
    assign IFID_PCPlus = ifid_pcplus_q;
    assign IFID_Valid  = ifid_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] PC = '0;
    logic          Halt = 1'b0;
    logic          Stall = 1'b0;
    logic          Flush = 1'b0;
    logic          StopPC;
    logic [DW-1:0] IFID_Instr;
    logic [AW-1:0] IFID_PC;
    logic [AW-1:0] IFID_PCPlus;
    logic          IFID_Valid;
    logic          fetch_err;

    fetch_stage_if #(.AW(AW), .DW(DW)) imem_if ();

    fetch_stage #(
        .AW(AW), .DW(DW), .PC_INC(16'd2), .NOP(16'h0000), .WAIT_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .PC(PC), .Halt(Halt), .Stall(Stall), .Flush(Flush),
        .imem(imem_if.master), .StopPC(StopPC), .IFID_Instr(IFID_Instr),
        .IFID_PC(IFID_PC), .IFID_PCPlus(IFID_PCPlus), .IFID_Valid(IFID_Valid),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pcp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        sb_en = 1'b0;
    logic [15:0] order_next = 16'h0000;
    logic        pend = 1'b0;
    logic [15:0] pend_addr = 16'h0000;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h3C5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [15:0] pc, input logic st, input logic fl,
                       input logic ht, input logic ak, input logic [15:0] rd);
        @(posedge clk);
        #1;
        rst = r; PC = pc; Stall = st; Flush = fl; Halt = ht;
        imem_if.imem_ack = ak;
        imem_if.imem_rdata = rd;
        @(negedge clk);
    endtask

    // Monitor: every instruction ID consumes must be the next one in the expected stream
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (pend) begin
                chk("req_stable", imem_if.imem_req, 1);
                chk("addr_stable", imem_if.imem_addr, pend_addr);
            end
            if (IFID_Valid && !Stall && !Flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got instr %h at pc %h, expected none", IFID_Instr, IFID_PC);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_instr", IFID_Instr, e.instr);
                    chk("sb_pc", IFID_PC, e.pc);
                    chk("sb_pcplus", IFID_PCPlus, e.pcp);
                    chk("prog_order", IFID_PC, order_next);
                    order_next = IFID_PC + 16'd2;
                end
            end
            pend      = imem_if.imem_req && !imem_if.imem_ack;
            pend_addr = imem_if.imem_addr;
        end else begin
            pend = 1'b0;
        end
    end

    initial begin
        logic [15:0] pc_m, tgt, stale_addr;
        logic        stale, ack, hp;
        int          streak;

        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 16'h0000;

        // Reset cycle: no request, PC held, ack ignored
        cyc(1, 16'h0000, 0, 0, 0, 1, 16'hFFFF);
        chk("rst_req", imem_if.imem_req, 0);
        chk("rst_stoppc", StopPC, 1);

        // Zero-wait fetch right after reset
        cyc(0, 16'h0000, 0, 0, 0, 1, 16'h1234);
        chk("rst_valid", IFID_Valid, 0);
        chk("rst_instr", IFID_Instr, 16'h0000);
        chk("rst_pc", IFID_PC, 0);
        chk("rst_pcplus", IFID_PCPlus, 0);
        chk("rst_err", fetch_err, 0);
        chk("t1_req", imem_if.imem_req, 1);
        chk("t1_addr", imem_if.imem_addr, 16'h0000);
        chk("t1_stoppc", StopPC, 0);

        // Three wait states then ack
        for (int i = 0; i < 4; i++) begin
            cyc(0, 16'h0002, 0, 0, 0, (i == 3), 16'hABCD);
            if (i == 0) begin
                chk("t1_instr", IFID_Instr, 16'h1234);
                chk("t1_pcplus", IFID_PCPlus, 16'h0002);
                chk("t1_valid", IFID_Valid, 1);
            end else begin
                chk("t2_bubble", IFID_Valid, 0);
            end
            chk("t2_stoppc", StopPC, (i == 3) ? 0 : 1);
        end

        // Ack while stalled parks the instruction
        cyc(0, 16'h0004, 1, 0, 0, 1, 16'h5555);
        chk("t2_instr", IFID_Instr, 16'hABCD);
        chk("t2_pc", IFID_PC, 16'h0002);
        chk("t3_stoppc", StopPC, 0);
        cyc(0, 16'h0006, 1, 0, 0, 0, 16'h0000);
        chk("t3_hold_req", imem_if.imem_req, 0);
        chk("t3_hold_instr", IFID_Instr, 16'hABCD);
        chk("t3_hold_valid", IFID_Valid, 1);
        cyc(0, 16'h0006, 0, 0, 0, 0, 16'h0000);
        chk("t3_rel_req", imem_if.imem_req, 0);

        // Flush with a request in flight at 0x0040
        cyc(0, 16'h0040, 0, 1, 0, 0, 16'h0000);
        chk("t3_parked_instr", IFID_Instr, 16'h5555);
        chk("t3_parked_pc", IFID_PC, 16'h0004);
        chk("t4_req", imem_if.imem_req, 1);
        chk("t4_addr", imem_if.imem_addr, 16'h0040);
        chk("t4_stoppc", StopPC, 0);
        cyc(0, 16'h0100, 0, 0, 0, 0, 16'h0000);
        chk("t4_drain_req", imem_if.imem_req, 1);
        chk("t4_drain_addr", imem_if.imem_addr, 16'h0040);
        chk("t4_drain_stoppc", StopPC, 1);
        chk("t4_bubble", IFID_Valid, 0);
        cyc(0, 16'h0100, 0, 0, 0, 1, 16'hDEAD);
        chk("t4_drain_ack_stoppc", StopPC, 1);
        cyc(0, 16'h0100, 0, 0, 0, 0, 16'h0000);
        chk("t4_dropped", IFID_Valid, 0);
        chk("t4_new_addr", imem_if.imem_addr, 16'h0100);

        // PCPlus wraps
        cyc(0, 16'hFFFE, 0, 0, 0, 1, 16'h7777);
        chk("t5_stoppc", StopPC, 0);
        cyc(0, 16'h0000, 0, 0, 0, 0, 16'h0000);
        chk("t5_instr", IFID_Instr, 16'h7777);
        chk("t5_pc", IFID_PC, 16'hFFFE);
        chk("t5_pcplus", IFID_PCPlus, 16'h0000);

        // Randomized run against the program-order reference model, ending in Halt
        cyc(1, 16'h0000, 0, 0, 0, 0, 16'h0000);
        sb.delete();
        pc_m = 16'h0000; stale = 1'b0; stale_addr = 16'h0000; streak = 0;
        order_next = 16'h0000;
        sb_en = 1'b1;
        for (int n = 0; n < 3020; n++) begin
            hp = (n >= 3000);
            @(posedge clk);
            #1;
            rst   = 1'b0;
            PC    = pc_m;
            Halt  = hp;
            Stall = hp ? 1'b0 : ($urandom_range(0, 3) == 0);
            Flush = hp ? 1'b0 : ($urandom_range(0, 11) == 0);
            tgt   = 16'($urandom) & 16'hFFFE;
            #1;
            ack = imem_if.imem_req && (streak == 3 || $urandom_range(0, 2) != 0);
            imem_if.imem_ack   = ack;
            imem_if.imem_rdata = ack ? mem_word(imem_if.imem_addr) : 16'($urandom);
            @(negedge clk);
            if (imem_if.imem_req && !ack) streak++;
            else streak = 0;
            if (ack) begin
                if (stale) begin
                    chk("stale_addr", imem_if.imem_addr, stale_addr);
                    stale = 1'b0;
                end else begin
                    sb.push_back('{instr: mem_word(pc_m), pc: pc_m, pcp: pc_m + 16'd2});
                end
            end
            if (Flush) begin
                if (imem_if.imem_req && !ack && !stale) begin
                    stale      = 1'b1;
                    stale_addr = pc_m;
                end
                sb.delete();
                order_next = tgt;
                pc_m = tgt;
            end else if (!StopPC) begin
                pc_m = pc_m + 16'd2;
            end
        end
        chk("halt_req", imem_if.imem_req, 0);
        chk("halt_stoppc", StopPC, 1);
        chk("halt_sb_empty", sb.size(), 0);
        chk("rand_no_err", fetch_err, 0);
        sb_en = 1'b0;

        // Timeout with WAIT_MAX=4, then Halt completes the request
        cyc(1, 16'h0020, 0, 0, 0, 0, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 16'h0020, 0, 0, 0, 0, 16'h0000);
            chk("t6_err", fetch_err, (k == 5) ? 1 : 0);
            chk("t6_req", imem_if.imem_req, 1);
        end
        cyc(0, 16'h0020, 0, 0, 1, 1, 16'hBEEF);
        chk("t6_sticky", fetch_err, 1);
        chk("t6_ack_stoppc", StopPC, 0);
        cyc(0, 16'h0022, 0, 0, 0, 0, 16'h0000);
        chk("t6_halted_req", imem_if.imem_req, 0);
        chk("t6_halted_stoppc", StopPC, 1);
        chk("t6_last_instr", IFID_Instr, 16'hBEEF);
        chk("t6_last_valid", IFID_Valid, 1);
        cyc(0, 16'h0022, 0, 0, 0, 1, 16'h0000);
        chk("t6_halted_bubble", IFID_Valid, 0);
        chk("t6_halted_stays", imem_if.imem_req, 0);
        chk("t6_err_final", fetch_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
